// File: rtl/hidden_layer_mac.sv
// Hidden-layer forward-pass engine: for every hidden node, multiply-accumulate all
// input pixels against that node's weights, activate, and write one byte to the hidden RAM.
module hidden_layer_mac #(
    parameter int NUM_INPUTS = 784,
    parameter int NUM_HIDDEN = 32,
    parameter int ACC_W      = 26,
    parameter int SHIFT      = 7
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic [$clog2(NUM_INPUTS)-1:0]             in_addr,
    input  logic [7:0]                                in_data,
    output logic [$clog2(NUM_INPUTS*NUM_HIDDEN)-1:0]  w_addr,
    input  logic [7:0]                                w_data,
    output logic                                      h_we,
    output logic [4:0]                                h_addr,
    output logic [7:0]                                h_data,
    output logic                                      busy,
    output logic                                      done,
    output logic [1:0]                                state_dbg
);

    localparam int IA_W = $clog2(NUM_INPUTS);
    localparam int WA_W = $clog2(NUM_INPUTS * NUM_HIDDEN);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, WRITE} state_t;

    state_t                  state, state_n;
    logic [4:0]              node, node_n;
    logic [IA_W-1:0]         i_n;
    logic [WA_W-1:0]         w_addr_n;
    logic                    h_we_n;
    logic [4:0]              h_addr_n;
    logic [7:0]              h_data_n;
    logic                    busy_n, done_n;
    logic                    valid;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] acc, acc_next, acc_shr;
    logic [7:0]              act;

    assign state_dbg = state;

    // Pixel is unsigned, so a zero sign bit is prepended before the signed multiply.
    assign prod     = $signed({1'b0, in_data}) * $signed(w_data);
    assign acc_next = valid ? acc + $signed({{(ACC_W-17){prod[16]}}, prod}) : acc;
    assign acc_shr  = acc_next >>> SHIFT;

    // Rectify, shift, saturate to 8 bits; DRAIN feeds acc_next so the last product counts.
    always_comb begin
        if (acc_next[ACC_W-1])
            act = 8'd0;
        else if (|acc_shr[ACC_W-1:8])
            act = 8'hFF;
        else
            act = acc_shr[7:0];
    end

    always_comb begin
        state_n  = state;
        node_n   = node;
        i_n      = in_addr;
        w_addr_n = w_addr;
        h_we_n   = 1'b0;
        h_addr_n = h_addr;
        h_data_n = h_data;
        busy_n   = busy;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = MAC;
                    node_n   = '0;
                    i_n      = '0;
                    w_addr_n = '0;
                    busy_n   = 1'b1;
                end
            end
            MAC: begin
                if (in_addr == IA_W'(NUM_INPUTS - 1)) begin
                    state_n = DRAIN;
                end else begin
                    i_n      = in_addr + 1'b1;
                    w_addr_n = w_addr + 1'b1;
                end
            end
            DRAIN: begin
                state_n  = WRITE;
                h_we_n   = 1'b1;
                h_addr_n = node;
                h_data_n = act;
            end
            WRITE: begin
                i_n = '0;
                if (node == 5'(NUM_HIDDEN - 1)) begin
                    state_n  = IDLE;
                    w_addr_n = '0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end else begin
                    // Weight rows are contiguous, so the next node's row starts one past this one's end.
                    state_n  = MAC;
                    node_n   = node + 1'b1;
                    w_addr_n = w_addr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            node    <= '0;
            in_addr <= '0;
            w_addr  <= '0;
            h_we    <= 1'b0;
            h_addr  <= '0;
            h_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            acc     <= '0;
        end else begin
            state   <= state_n;
            node    <= node_n;
            in_addr <= i_n;
            w_addr  <= w_addr_n;
            h_we    <= h_we_n;
            h_addr  <= h_addr_n;
            h_data  <= h_data_n;
            busy    <= busy_n;
            done    <= done_n;
            valid   <= (state == MAC);
            acc     <= (state == IDLE || state == WRITE) ? '0 : acc_next;
        end
    end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Bench for hidden_layer_mac: a small instance (4 inputs, 2 nodes, no shift) for vectors
// and corner sequences, plus two default-size instances run as one concurrent full pass.
module tb_hidden_layer_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int act(input longint acc, input int sh);
        longint v;
        if (acc < 0) return 0;
        v = acc >>> sh;
        return (v > 255) ? 255 : int'(v);
    endfunction

    // ---------------- small instance ----------------
    logic       s_rst, s_start, s_h_we, s_busy, s_done;
    logic [1:0] s_in_addr, s_state;
    logic [2:0] s_w_addr;
    logic [7:0] s_in_data, s_w_data, s_h_data;
    logic [4:0] s_h_addr;
    int         s_pix [0:3];
    int         s_w   [0:7];
    logic [12:0] exp_q [$];

    hidden_layer_mac #(.NUM_INPUTS(4), .NUM_HIDDEN(2), .ACC_W(26), .SHIFT(0)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start),
        .in_addr(s_in_addr), .in_data(s_in_data),
        .w_addr(s_w_addr), .w_data(s_w_data),
        .h_we(s_h_we), .h_addr(s_h_addr), .h_data(s_h_data),
        .busy(s_busy), .done(s_done), .state_dbg(s_state)
    );

    always @(posedge clk) begin
        s_in_data <= 8'(s_pix[s_in_addr]);
        s_w_data  <= 8'(s_w[s_w_addr]);
    end

    function automatic int s_model(input int k);
        longint acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(s_pix[i]) * s_w[k*4+i];
        return act(acc, 0);
    endfunction

    // One full pass: writes at cycles 6 and 12, done at 13, idle at 14.
    task automatic small_pass(input string tag, input int start_again_at);
        logic [12:0] e;
        @(negedge clk);
        s_start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check($sformatf("%s we c%0d", tag, c), s_h_we, (c % 6 == 0) && (c <= 12));
            check($sformatf("%s busy c%0d", tag, c), s_busy, c <= 12);
            check($sformatf("%s done c%0d", tag, c), s_done, c == 13);
            if (s_h_we) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL %s unexpected write: addr %0d data %0d", tag, s_h_addr, s_h_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s write c%0d {addr,data}", tag, c), {s_h_addr, s_h_data}, e);
                end
            end
            s_start = (c == start_again_at);
        end
        check($sformatf("%s leftover writes", tag), exp_q.size(), 0);
    endtask

    // ---------------- default-size instances ----------------
    logic        b_rst, b_start;
    logic        a_h_we, a_busy, a_done, b_h_we, b_busy, b_done;
    logic [9:0]  a_in_addr, b_in_addr;
    logic [14:0] a_w_addr, b_w_addr;
    logic [7:0]  a_in_data, a_w_data, a_h_data, b_in_data, b_w_data, b_h_data;
    logic [4:0]  a_h_addr, b_h_addr;
    logic [1:0]  a_state, b_state;
    int          a_pix [0:783];
    int          b_pix [0:783];
    int          a_w   [0:25087];
    int          b_w   [0:25087];
    logic [12:0] exp_a_q [$];
    logic [12:0] exp_b_q [$];

    hidden_layer_mac u_big_a (
        .clk(clk), .rst(b_rst), .start(b_start),
        .in_addr(a_in_addr), .in_data(a_in_data),
        .w_addr(a_w_addr), .w_data(a_w_data),
        .h_we(a_h_we), .h_addr(a_h_addr), .h_data(a_h_data),
        .busy(a_busy), .done(a_done), .state_dbg(a_state)
    );

    hidden_layer_mac u_big_b (
        .clk(clk), .rst(b_rst), .start(b_start),
        .in_addr(b_in_addr), .in_data(b_in_data),
        .w_addr(b_w_addr), .w_data(b_w_data),
        .h_we(b_h_we), .h_addr(b_h_addr), .h_data(b_h_data),
        .busy(b_busy), .done(b_done), .state_dbg(b_state)
    );

    always @(posedge clk) begin
        a_in_data <= 8'(a_pix[a_in_addr]);
        a_w_data  <= 8'(a_w[a_w_addr]);
        b_in_data <= 8'(b_pix[b_in_addr]);
        b_w_data  <= 8'(b_w[b_w_addr]);
    end

    function automatic int big_model(input bit use_b, input int k);
        longint acc = 0;
        for (int i = 0; i < 784; i++) begin
            if (use_b) acc += longint'(b_pix[i]) * b_w[k*784+i];
            else       acc += longint'(a_pix[i]) * a_w[k*784+i];
        end
        return act(acc, 7);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    pix;
        int    w0;
        int    w1;
        int    exp0;
        int    exp1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [12:0] e;
        int lim_w, lim_p;

        vecs[0] = '{"ones",      1,    1,    1,   4,   4};
        vecs[1] = '{"rectify",   2,   -1,    3,   0,  24};
        vecs[2] = '{"saturate",  255, 127,  127, 255, 255};
        vecs[3] = '{"just_over", 64,   1,    0,  255,   0};
        vecs[4] = '{"max_exact", 63,   1, -128,  252,   0};
        vecs[5] = '{"zero_pix",  0, -128,  127,    0,   0};

        s_rst = 1'b1; b_rst = 1'b1; s_start = 1'b0; b_start = 1'b0;
        for (int i = 0; i < 4; i++) s_pix[i] = 0;
        for (int i = 0; i < 8; i++) s_w[i] = 0;
        for (int i = 0; i < 784; i++) begin a_pix[i] = 0; b_pix[i] = 0; end
        for (int i = 0; i < 25088; i++) begin a_w[i] = 0; b_w[i] = 0; end
        repeat (3) @(negedge clk);

        check("rst s_busy", s_busy, 0);     check("rst s_done", s_done, 0);
        check("rst s_h_we", s_h_we, 0);     check("rst s_h_addr", s_h_addr, 0);
        check("rst s_h_data", s_h_data, 0); check("rst s_in_addr", s_in_addr, 0);
        check("rst s_w_addr", s_w_addr, 0);
        check("rst a_busy", a_busy, 0);     check("rst a_done", a_done, 0);
        check("rst a_h_we", a_h_we, 0);     check("rst a_w_addr", a_w_addr, 0);
        check("rst b_h_data", b_h_data, 0); check("rst b_in_addr", b_in_addr, 0);
        s_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Table vectors with uniform pixels and per-node uniform weights.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                s_pix[i]  = vecs[v].pix;
                s_w[i]    = vecs[v].w0;
                s_w[4+i]  = vecs[v].w1;
            end
            exp_q.push_back({5'd0, 8'(vecs[v].exp0)});
            exp_q.push_back({5'd1, 8'(vecs[v].exp1)});
            small_pass(vecs[v].name, 0);
            repeat (2) @(negedge clk);
        end

        // start pulsed again at cycle 3 of a pass must be ignored.
        for (int i = 0; i < 4; i++) begin s_pix[i] = 2; s_w[i] = -1; s_w[4+i] = 3; end
        exp_q.push_back({5'd0, 8'd0});
        exp_q.push_back({5'd1, 8'd24});
        small_pass("restart_ignored", 3);
        repeat (2) @(negedge clk);

        // Reset during node 1: outputs clear at once, no further writes.
        for (int i = 0; i < 4; i++) begin s_pix[i] = 1; s_w[i] = 1; s_w[4+i] = 1; end
        @(negedge clk);
        s_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (c == 6) begin
                check("midrst node0 we", s_h_we, 1);
                check("midrst node0 {addr,data}", {s_h_addr, s_h_data}, {5'd0, 8'd4});
            end
        end
        s_rst = 1'b1;
        #1;
        check("midrst busy", s_busy, 0);       check("midrst h_we", s_h_we, 0);
        check("midrst done", s_done, 0);       check("midrst in_addr", s_in_addr, 0);
        check("midrst w_addr", s_w_addr, 0);   check("midrst h_addr", s_h_addr, 0);
        check("midrst h_data", s_h_data, 0);
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("postrst we c%0d", c), s_h_we, 0);
            check($sformatf("postrst busy c%0d", c), s_busy, 0);
        end
        exp_q.push_back({5'd0, 8'd4});
        exp_q.push_back({5'd1, 8'd4});
        small_pass("after_reset", 0);
        repeat (2) @(negedge clk);

        // Randomized passes against the arithmetic model.
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 2))
                0:       lim_w = 2;
                1:       lim_w = 8;
                default: lim_w = 127;
            endcase
            lim_p = ($urandom_range(0, 1) == 0) ? 15 : 255;
            for (int i = 0; i < 4; i++) s_pix[i] = int'($urandom_range(0, lim_p));
            for (int i = 0; i < 8; i++) s_w[i] = int'($urandom_range(0, 2 * lim_w)) - lim_w;
            exp_q.push_back({5'd0, 8'(s_model(0))});
            exp_q.push_back({5'd1, 8'(s_model(1))});
            small_pass($sformatf("rand%0d", r), 0);
            @(negedge clk);
        end

        // Full-size pass. A: pixels 255, node0 weights -128, node1 weights 127.
        // B: pixels 1, node0 weights 1 (784>>>7 = 6). Other nodes random.
        for (int i = 0; i < 784; i++) begin a_pix[i] = 255; b_pix[i] = 1; end
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < 784; i++) begin
                a_w[k*784+i] = (k == 0) ? -128 : (k == 1) ? 127 : int'($urandom_range(0, 255)) - 128;
                b_w[k*784+i] = (k == 0) ? 1 : int'($urandom_range(0, 255)) - 128;
            end
        end
        exp_a_q.push_back({5'd0, 8'd0});
        exp_a_q.push_back({5'd1, 8'd255});
        exp_b_q.push_back({5'd0, 8'd6});
        for (int k = 2; k < 32; k++) exp_a_q.push_back({5'(k), 8'(big_model(0, k))});
        for (int k = 1; k < 32; k++) exp_b_q.push_back({5'(k), 8'(big_model(1, k))});

        @(negedge clk);
        b_start = 1'b1;
        for (int c = 1; c <= 25154; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            check($sformatf("a we c%0d", c), a_h_we, (c % 786 == 0) && (c <= 25152));
            check($sformatf("b we c%0d", c), b_h_we, (c % 786 == 0) && (c <= 25152));
            check($sformatf("a busy c%0d", c), a_busy, c <= 25152);
            check($sformatf("b done c%0d", c), b_done, c == 25153);
            check($sformatf("a done c%0d", c), a_done, c == 25153);
            if (a_h_we && exp_a_q.size() != 0) begin
                e = exp_a_q.pop_front();
                check($sformatf("a write c%0d {addr,data}", c), {a_h_addr, a_h_data}, e);
            end
            if (b_h_we && exp_b_q.size() != 0) begin
                e = exp_b_q.pop_front();
                check($sformatf("b write c%0d {addr,data}", c), {b_h_addr, b_h_data}, e);
            end
        end
        check("a leftover writes", exp_a_q.size(), 0);
        check("b leftover writes", exp_b_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
